// File: rtl/pc_fetch_unit.sv
// Fetch PC register and instruction-fetch front end: issues one word request at a time to
// instruction memory and buffers PC-tagged responses in a small FIFO for decode.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc_i,
   input  logic        redirect_i,
   output logic        imem_req_valid_o,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_req_ready_i,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i
);

   localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
   localparam logic [CntW-1:0] Depth = CntW'(BUF_DEPTH);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     req_pc_q, req_pc_d;
   logic            discard_q, discard_d;
   logic [31:0]     buf_pc_q   [BUF_DEPTH];
   logic [31:0]     buf_inst_q [BUF_DEPTH];
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push, pop, req_fire;

   assign imem_req_valid_o = (state_q == StReq);
   assign imem_req_addr_o  = fetch_pc_q;
   assign inst_valid_o     = (count_q != '0);
   assign inst_o           = buf_inst_q[rd_ptr_q];
   assign inst_pc_o        = buf_pc_q[rd_ptr_q];
   assign req_fire         = (state_q == StReq) && imem_req_ready_i;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      discard_d  = discard_q;
      // A redirect flushes the FIFO, so neither the response nor the pop takes effect.
      push = (state_q == StWait) && imem_rsp_valid_i && !discard_q && !redirect_i;
      pop  = inst_valid_o && inst_ready_i && !redirect_i;
      count_d  = count_q + CntW'(push) - CntW'(pop);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(push);

      unique case (state_q)
         StIdle: begin
            if (count_d < Depth) state_d = StReq;
         end
         StReq: begin
            if (imem_req_ready_i) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = StWait;
            end
         end
         StWait: begin
            if (imem_rsp_valid_i) begin
               discard_d = 1'b0;
               state_d   = (count_d < Depth) ? StReq : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (redirect_i) begin
         fetch_pc_d = {npc_i[31:2], 2'b00};
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // Still owed a response that belongs to the old path: wait for it and drop it.
         if (req_fire || ((state_q == StWait) && !imem_rsp_valid_i)) begin
            discard_d = 1'b1;
            state_d   = StWait;
         end else begin
            discard_d = 1'b0;
            state_d   = StReq;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         discard_q  <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            buf_pc_q[i]   <= '0;
            buf_inst_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         discard_q  <= discard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (push) begin
            buf_pc_q[wr_ptr_q]   <= req_pc_q;
            buf_inst_q[wr_ptr_q] <= imem_rsp_data_i;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change on the falling edge, outputs are sampled there.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] npc_i;
   logic        redirect_i;
   logic        imem_req_valid_o;
   logic [31:0] imem_req_addr_o;
   logic        imem_req_ready_i;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_ready_i;

   int nvec = 0;
   int nerr = 0;

   logic        auto_mem;
   logic        pend;
   logic [31:0] pend_addr;
   logic [31:0] req_log[$];
   logic [31:0] pop_pc_log[$];
   logic [31:0] pop_inst_log[$];

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .npc_i            (npc_i),
      .redirect_i       (redirect_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .inst_valid_o     (inst_valid_o),
      .inst_o           (inst_o),
      .inst_pc_o        (inst_pc_o),
      .inst_ready_i     (inst_ready_i)
   );

   always #5 clk = ~clk;

   // Called at a falling edge with the inputs for the coming rising edge already set.
   task automatic tick();
      if (auto_mem) begin
         imem_rsp_valid_i = pend;
         imem_rsp_data_i  = pend_addr | 32'hA000_0000;
         pend      = imem_req_valid_o && imem_req_ready_i;
         pend_addr = imem_req_addr_o;
      end
      if (imem_req_valid_o && imem_req_ready_i) req_log.push_back(imem_req_addr_o);
      if (inst_valid_o && inst_ready_i && !redirect_i) begin
         pop_pc_log.push_back(inst_pc_o);
         pop_inst_log.push_back(inst_o);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_i = 1'b0;
      npc_i = '0;
      imem_req_ready_i = 1'b1;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i = '0;
      inst_ready_i = 1'b1;
      auto_mem = 1'b1;
      pend = 1'b0;
      pend_addr = '0;
      req_log.delete();
      pop_pc_log.delete();
      pop_inst_log.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      nvec++; if (imem_req_valid_o !== 1'b0) begin nerr++;
         $display("FAIL rst_req_valid: got %h want 0", imem_req_valid_o); end
      nvec++; if (inst_valid_o !== 1'b0) begin nerr++;
         $display("FAIL rst_inst_valid: got %h want 0", inst_valid_o); end
      nvec++; if (inst_o !== 32'h0) begin nerr++;
         $display("FAIL rst_inst: got %h want 0", inst_o); end
      nvec++; if (inst_pc_o !== 32'h0) begin nerr++;
         $display("FAIL rst_inst_pc: got %h want 0", inst_pc_o); end
      nvec++; if (imem_req_addr_o !== 32'h0) begin nerr++;
         $display("FAIL rst_addr: got %h want 0", imem_req_addr_o); end
   endtask

   task automatic test_stream();
      do_reset();
      repeat (12) tick();
      nvec++; if (req_log.size() != 6) begin nerr++;
         $display("FAIL stream_req_count: got %0d want 6", req_log.size()); end
      nvec++; if (pop_pc_log.size() != 5) begin nerr++;
         $display("FAIL stream_pop_count: got %0d want 5", pop_pc_log.size()); end
      for (int i = 0; i < 3; i++) begin
         nvec++; if (req_log[i] !== 32'(4 * i)) begin nerr++;
            $display("FAIL stream_req_addr[%0d]: got %h want %h", i, req_log[i], 4 * i); end
         nvec++; if (pop_pc_log[i] !== 32'(4 * i)) begin nerr++;
            $display("FAIL stream_pop_pc[%0d]: got %h want %h", i, pop_pc_log[i], 4 * i); end
      end
      nvec++; if (pop_inst_log[1] !== 32'hA000_0004) begin nerr++;
         $display("FAIL stream_pop_inst[1]: got %h want a0000004", pop_inst_log[1]); end
   endtask

   task automatic test_backpressure();
      do_reset();
      inst_ready_i = 1'b0;
      repeat (12) tick();
      nvec++; if (req_log.size() != 2) begin nerr++;
         $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
      nvec++; if (imem_req_valid_o !== 1'b0) begin nerr++;
         $display("FAIL bp_req_valid: got %h want 0", imem_req_valid_o); end
      nvec++; if (inst_pc_o !== 32'h0 || inst_o !== 32'hA000_0000) begin nerr++;
         $display("FAIL bp_head: got %h/%h want 0/a0000000", inst_pc_o, inst_o); end
      inst_ready_i = 1'b1;
      repeat (4) tick();
      nvec++; if (req_log.size() < 3 || req_log[2] !== 32'h8) begin nerr++;
         $display("FAIL bp_resume_addr: got %h want 8", req_log[2]); end
      nvec++; if (pop_pc_log.size() != 3 || pop_pc_log[1] !== 32'h4 || pop_pc_log[2] !== 32'h8)
         begin nerr++; $display("FAIL bp_resume_pops: got %0d pops want 0,4,8",
                                pop_pc_log.size()); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      auto_mem = 1'b0;
      inst_ready_i = 1'b0;
      tick();                                   // idle
      tick();                                   // request 0
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0011;
      tick();                                   // buffered
      imem_rsp_valid_i = 1'b0;
      tick();                                   // request 4
      redirect_i = 1'b1; npc_i = 32'h0000_0103;
      tick();                                   // redirect in wait
      redirect_i = 1'b0;
      nvec++; if (inst_valid_o !== 1'b0) begin nerr++;
         $display("FAIL rw_flush: got %h want 0", inst_valid_o); end
      nvec++; if (imem_req_valid_o !== 1'b0 || imem_req_addr_o !== 32'h100) begin nerr++;
         $display("FAIL rw_hold: got %h/%h want 0/100", imem_req_valid_o, imem_req_addr_o); end
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hDEAD_BEEF;
      tick();                                   // stale response
      imem_rsp_valid_i = 1'b0;
      nvec++; if (inst_valid_o !== 1'b0) begin nerr++;
         $display("FAIL rw_stale_dropped: got %h want 0", inst_valid_o); end
      nvec++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h100) begin nerr++;
         $display("FAIL rw_new_req: got %h/%h want 1/100", imem_req_valid_o, imem_req_addr_o); end
      tick();
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_1234;
      tick();
      imem_rsp_valid_i = 1'b0;
      nvec++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h100 || inst_o !== 32'h1234)
         begin nerr++; $display("FAIL rw_deliver: got %h/%h/%h want 1/100/1234",
                                inst_valid_o, inst_pc_o, inst_o); end
   endtask

   task automatic test_redirect_same_cycle();
      do_reset();
      auto_mem = 1'b0;
      tick();
      redirect_i = 1'b1; npc_i = 32'h0000_0200;
      tick();                                   // redirect on handshake
      nvec++; if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin nerr++;
         $display("FAIL rs_hs: got %h/%h want 0/0", imem_req_valid_o, inst_valid_o); end
      npc_i = 32'h0000_0300;
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hBAD0_0000;
      tick();                                   // redirect with response
      redirect_i = 1'b0; imem_rsp_valid_i = 1'b0;
      nvec++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h300
                  || inst_valid_o !== 1'b0) begin nerr++;
         $display("FAIL rs_rsp: got %h/%h/%h want 1/300/0",
                  imem_req_valid_o, imem_req_addr_o, inst_valid_o); end
      tick();
      nvec++; if (inst_valid_o !== 1'b0) begin nerr++;
         $display("FAIL rs_no_spurious: got %h want 0", inst_valid_o); end
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_5555;
      tick();
      imem_rsp_valid_i = 1'b0;
      nvec++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h300 || inst_o !== 32'h5555)
         begin nerr++; $display("FAIL rs_deliver: got %h/%h/%h want 1/300/5555",
                                inst_valid_o, inst_pc_o, inst_o); end
      nvec++; if (req_log.size() != 2 || req_log[1] !== 32'h300) begin nerr++;
         $display("FAIL rs_req_log: got %0d reqs want 2", req_log.size()); end
   endtask

   task automatic test_wrap();
      do_reset();
      redirect_i = 1'b1; npc_i = 32'hFFFF_FFFF;
      tick();
      redirect_i = 1'b0;
      nvec++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'hFFFF_FFFC) begin nerr++;
         $display("FAIL wrap_first: got %h/%h want 1/fffffffc",
                  imem_req_valid_o, imem_req_addr_o); end
      repeat (2) tick();
      nvec++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0) begin nerr++;
         $display("FAIL wrap_next: got %h/%h want 1/0", imem_req_valid_o, imem_req_addr_o); end
      nvec++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'hFFFF_FFFC) begin nerr++;
         $display("FAIL wrap_inst_pc: got %h/%h want 1/fffffffc", inst_valid_o, inst_pc_o); end
   endtask

   task automatic test_async_reset();
      do_reset();
      auto_mem = 1'b0;
      inst_ready_i = 1'b0;
      tick();
      tick();
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0077;
      tick();
      imem_rsp_valid_i = 1'b0;
      tick();                                   // request 4 in flight
      nvec++; if (inst_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8) begin nerr++;
         $display("FAIL ar_pre: got %h/%h want 1/8", inst_valid_o, imem_req_addr_o); end
      #1 rst = 1'b1;
      #1;
      nvec++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_pc_o !== 32'h0
                  || imem_req_valid_o !== 1'b0 || imem_req_addr_o !== 32'h0) begin nerr++;
         $display("FAIL ar_immediate: got %h/%h/%h/%h/%h want all 0", inst_valid_o, inst_o,
                  inst_pc_o, imem_req_valid_o, imem_req_addr_o); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      nvec++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0) begin nerr++;
         $display("FAIL ar_restart: got %h/%h want 1/0", imem_req_valid_o, imem_req_addr_o); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_same_cycle();
      test_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
